// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell (two half adders plus carry register).
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             c;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] load_b;
  logic             load_c;
  logic [1:0]       ha0;
  logic [1:0]       ha1;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] sum_nxt;

  // Returns {carry, sum} of a single half adder.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and inject a carry-in of one.
  assign load_b = sub ? ~b : b;
  assign load_c = sub;
`else
  assign load_b = b;
  assign load_c = 1'b0;
`endif

  assign ha0       = half_add(a_sh[0], b_sh[0]);
  assign ha1       = half_add(ha0[0], c);
  assign sum_bit   = ha1[0];
  assign carry_nxt = ha0[1] | ha1[1];
  assign sum_nxt   = WIDTH'({sum_bit, sum} >> 1);

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT) || (state == DONE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= load_b;
            c     <= load_c;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          c    <= carry_nxt;
          sum  <= sum_nxt;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            carry_out <= carry_nxt;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): abstract arithmetic model plus directed vectors.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub_s = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s),
`endif
    .in_ready(in_ready),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 computing (countdown of W edges), 2 result held.
  int         m_ph = 0;
  int         m_cnt = 0;
  logic [W:0] m_pend = '0;
  logic [W:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_cnt = 0; m_res = '0;
    end else begin
      case (m_ph)
        0: if (start) begin
          if (sub_s) begin
            m_pend[W-1:0] = a - b;
            m_pend[W]     = (a >= b);
          end else begin
            m_pend = {1'b0, a} + {1'b0, b};
          end
          m_cnt = W;
          m_ph  = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin m_ph = 2; m_res = m_pend; end
        end
        default: if (out_ready) m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_ph == 0});
      chk("busy", {31'b0, busy}, {31'b0, m_ph != 0});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_ph == 2});
      if (m_ph != 1) begin
        chk("sum_model", {24'b0, sum}, {24'b0, m_res[W-1:0]});
        chk("carry_model", {31'b0, carry_out}, {31'b0, m_res[W]});
      end
    end
  end

  // Issue one operation from IDLE; returns edges from accept to out_valid.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       output int lat);
    int n;
    a = ta; b = tb_v; sub_s = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
  endtask

  task automatic op_check(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic [W-1:0] es, input logic ec);
    int lat;
    do_op(ta, tb_v, ts, lat);
    chk({nm, "_latency"}, lat, 8);
    chk({nm, "_sum"}, {24'b0, sum}, {24'b0, es});
    chk({nm, "_carry"}, {31'b0, carry_out}, {31'b0, ec});
    @(posedge clk); #1;
    chk({nm, "_idle_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #1 rst = 1'b1;
    #10;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum", {24'b0, sum}, 32'd0);
    chk("rst_carry", {31'b0, carry_out}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    op_check("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    op_check("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op_check("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    op_check("add_aa_55", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
    op_check("add_c3_7e", 8'hC3, 8'h7E, 1'b0, 8'h41, 1'b1);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    do_op(8'h80, 8'h80, 1'b0, lat);
    chk("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_sum", {24'b0, sum}, 32'h00);
      chk("bp_carry", {31'b0, carry_out}, 32'd1);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", {31'b0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);

    // Busy rejection: start with other operands during SHIFT is ignored.
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 8'h11; b = 8'h22; start = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("busy_rej_valid", {31'b0, out_valid}, 32'd1);
    chk("busy_rej_sum", {24'b0, sum}, 32'h03);
    chk("busy_rej_carry", {31'b0, carry_out}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("busy_rej_no_second", {31'b0, busy}, 32'd0);

    // Asynchronous reset four cycles into SHIFT.
    a = 8'h55; b = 8'h66; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_sum", {24'b0, sum}, 32'd0);
    chk("midrst_carry", {31'b0, carry_out}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    op_check("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op_check("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    op_check("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    op_check("sub0_add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder built around a single one-bit adder cell (half adder pair plus carry register), LSB first.
Loads two WIDTH-bit operands, adds one bit per clock, and returns an N-bit sum and carry-out over a valid/ready handshake.
Sits downstream of the one-bit adder cell. It consumes the cell's sum and carry every cycle and registers the carry as the next cycle's carry-in.
Trades cycles for area compared with the ripple adders elsewhere in the design.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; operands accepted when start=1 and in_ready=1 at a rising edge
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
in_ready  output  1  high only in IDLE
busy  output  1  high in SHIFT and DONE
out_valid  output  1  high only in DONE
out_ready  input  1  consumer accepts result when out_valid=1 and out_ready=1 at a rising edge
sum  output  WIDTH  result, stable while out_valid=1
carry_out  output  1  final carry, stable while out_valid=1
sub  input  1  only present with SERIAL_ADDER_SUB_EN; sampled on accept

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All state clears immediately on rst, independent of clk.
- Reset values: state=IDLE, in_ready=1, busy=0, out_valid=0, sum=0, carry_out=0, internal shift registers and carry=0, bit counter=0.
- States: IDLE, SHIFT, DONE. in_ready, busy and out_valid decode from state only, with no combinational path from inputs.
- IDLE:
  - On start=1, load a_sh<=a, b_sh<=b, c<=0, cnt<=0, then go to SHIFT.
  - start=0 stays in IDLE.
  - sum and carry_out keep their previous values.
- SHIFT, each cycle:
  - s = a_sh[0]^b_sh[0]^c.
  - c <= majority(a_sh[0], b_sh[0], c).
  - sum <= {s, sum[WIDTH-1:1]}, i.e. shift right with the new bit entering at the MSB.
  - a_sh and b_sh shift right by 1; cnt <= cnt+1.
  - When cnt==WIDTH-1, the current bit is the last: go to DONE and load carry_out from the new carry.
- Latency: accept at edge E0; out_valid=1 after edge E0+WIDTH. WIDTH=8 gives 8 cycles in SHIFT.
- DONE:
  - Hold sum and carry_out until out_ready=1, then go to IDLE.
  - out_valid and in_ready are never high in the same cycle. Back-to-back operations therefore cost WIDTH+2 cycles minimum.
- start while busy=1 is ignored. No queuing, no error.
- a and b are don't-care except at the accept edge. Changing them during SHIFT has no effect.
- Arithmetic:
  - sum = (a+b) mod 2^WIDTH.
  - carry_out = bit WIDTH of a+b.
- WIDTH=1: one SHIFT cycle, then DONE.
- Reset mid-operation, in SHIFT or DONE: return to IDLE with reset values. Any partial sum is discarded. The next accept starts cleanly.
- Counter width is clog2(WIDTH+1) bits. No wrap occurs because the count terminates at WIDTH-1.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - Port sub exists and is sampled on accept.
  - sub=1 loads b_sh<=~b and c<=1, so sum = (a-b) mod 2^WIDTH.
  - carry_out=1 means no borrow (a>=b unsigned); carry_out=0 means borrow.
  - sub=0 behaves exactly as add.
- Undefined: no sub port, adder only, with no extra logic.

Test Plan:
- Reset, then 0x5A+0x3C with start pulse, out_ready=1 -> out_valid rises exactly 8 cycles after accept; sum=0x96, carry_out=0; in_ready=1 the cycle after.
- 0xFF+0x01 -> sum=0x00, carry_out=1. Then 0x00+0x00 -> sum=0x00, carry_out=0, with no carry left over from the previous operation.
- Backpressure: 0x80+0x80 with out_ready=0 for 5 cycles after out_valid -> sum=0x00 and carry_out=1 stay stable throughout. Release out_ready -> IDLE on the next edge.
- Busy rejection: start=1 with a=0x11, b=0x22 held for 3 cycles during SHIFT of 0x01+0x02 -> result is 0x03, and no second operation starts.
- Reset mid-op: assert rst asynchronously (between edges) 4 cycles into SHIFT -> outputs go to reset values immediately. After release, 0x0F+0x01 gives sum=0x10, carry_out=0.
- With SERIAL_ADDER_SUB_EN: sub=1, 0x10-0x01 -> sum=0x0F, carry_out=1. Then 0x01-0x02 -> sum=0xFF, carry_out=0.
